// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared constants and types for the data-memory port arbiter.
//   ARB_ADDR_W / ARB_DATA_W : default address and word widths
//   LOCK_CNT_W              : width of the D burst-lock counter
//   STAT_W                  : width of the optional statistics counters
//   owner_t                 : which requester owned the port last
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int LOCK_CNT_W = 8;
    localparam int STAT_W     = 16;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_pick.sv
// ----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection for the data-memory port arbiter.
// Ports:
//   p_req, d_req  : requests from the processor (P) and DMA engine (D)
//   d_lock        : D asks to keep ownership across consecutive cycles
//   last_owner    : requester granted most recently
//   lock_cnt      : consecutive contested D grants taken under d_lock
//   p_win, d_win  : one-hot winner, both low when nobody requests
// ----------------------------------------------------------------------------
module arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic                  p_req,
    input  logic                  d_req,
    input  logic                  d_lock,
    input  owner_t                last_owner,
    input  logic [LOCK_CNT_W-1:0] lock_cnt,
    output logic                  p_win,
    output logic                  d_win
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(MAX_LOCK);

    logic lock_hold;

    // A contested cycle goes to D only while its burst lock is still within
    // the starvation budget; otherwise ownership alternates round-robin.
    always_comb begin
        lock_hold = (last_owner == OWN_D) && d_lock && (lock_cnt < LOCK_LIMIT);
        p_win     = 1'b0;
        d_win     = 1'b0;
        if (p_req && d_req) begin
            if (lock_hold) begin
                d_win = 1'b1;
            end else if (last_owner == OWN_D) begin
                p_win = 1'b1;
            end else begin
                d_win = 1'b1;
            end
        end else begin
            p_win = p_req;
            d_win = d_req;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single dmem port between the processor data port (P) and a
// DMA/loader engine (D). Arbitration is per cycle and combinational; the
// winner's payload drives the memory, and load data is registered back to
// the winner one cycle after its grant.
//
// Ports:
//   clock, reset            : rising-edge clock, async active-low reset
//   p_* / d_* inputs        : request, address, write data, write enable,
//                             byte / half-word size and sign-extend controls
//   d_lock                  : D asks to keep ownership next cycle
//   p_gnt / d_gnt           : same-cycle grant
//   p_rdata/p_rvalid,
//   d_rdata/d_rvalid        : registered read return, valid for one cycle
//   *_to_mem                : request presented to dmem (all 0 when idle)
//   data_from_mem           : combinational read data from dmem
//   stat_*                  : saturating grant/conflict counters, present
//                             only when ARB_STATS_EN is defined
//
// Optional build macro: ARB_STATS_EN
// MAX_LOCK legal range is 1..255.
// ----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_LOCK = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p_req,
    input  logic [0:ADDR_W-1] p_addr,
    input  logic [0:DATA_W-1] p_wdata,
    input  logic              p_we,
    input  logic              p_byte,
    input  logic              p_half,
    input  logic              p_sext,
    output logic              p_gnt,
    output logic [0:DATA_W-1] p_rdata,
    output logic              p_rvalid,

    input  logic              d_req,
    input  logic [0:ADDR_W-1] d_addr,
    input  logic [0:DATA_W-1] d_wdata,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic              d_half,
    input  logic              d_sext,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic [0:DATA_W-1] d_rdata,
    output logic              d_rvalid,

    output logic [0:ADDR_W-1] addr_to_mem,
    output logic [0:DATA_W-1] data_to_mem,
    output logic              write_enable_to_mem,
    output logic              byte_to_mem,
    output logic              half_word_to_mem,
    output logic              sign_extend_to_mem,
`ifdef ARB_STATS_EN
    output logic [0:STAT_W-1] stat_p_grants,
    output logic [0:STAT_W-1] stat_d_grants,
    output logic [0:STAT_W-1] stat_conflicts,
`endif
    input  logic [0:DATA_W-1] data_from_mem
);

    owner_t                last_owner;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  p_win;
    logic                  d_win;
    logic                  p_take;
    logic                  d_take;

    arb_pick #(
        .MAX_LOCK   (MAX_LOCK)
    ) u_pick (
        .p_req      (p_req),
        .d_req      (d_req),
        .d_lock     (d_lock),
        .last_owner (last_owner),
        .lock_cnt   (lock_cnt),
        .p_win      (p_win),
        .d_win      (d_win)
    );

    // Grants are forced low while reset is held so the memory sees no
    // access even if requesters keep their lines asserted.
    assign p_take = p_win & reset;
    assign d_take = d_win & reset;
    assign p_gnt  = p_take;
    assign d_gnt  = d_take;

    // Steer the winner's payload onto the memory port; idle cycles drive 0.
    always_comb begin
        addr_to_mem         = '0;
        data_to_mem         = '0;
        write_enable_to_mem = 1'b0;
        byte_to_mem         = 1'b0;
        half_word_to_mem    = 1'b0;
        sign_extend_to_mem  = 1'b0;
        if (p_take) begin
            addr_to_mem         = p_addr;
            data_to_mem         = p_wdata;
            write_enable_to_mem = p_we;
            byte_to_mem         = p_byte;
            half_word_to_mem    = p_half;
            sign_extend_to_mem  = p_sext;
        end else if (d_take) begin
            addr_to_mem         = d_addr;
            data_to_mem         = d_wdata;
            write_enable_to_mem = d_we;
            byte_to_mem         = d_byte;
            half_word_to_mem    = d_half;
            sign_extend_to_mem  = d_sext;
        end
    end

    // Read return: capture dmem data at the edge closing the granted cycle.
    // The loser's rdata keeps its old value; writes never raise rvalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_rdata  <= '0;
            p_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_rvalid <= 1'b0;
        end else begin
            p_rvalid <= p_take & ~p_we;
            d_rvalid <= d_take & ~d_we;
            if (p_take && !p_we) begin
                p_rdata <= data_from_mem;
            end
            if (d_take && !d_we) begin
                d_rdata <= data_from_mem;
            end
        end
    end

    // Ownership history and the D burst-lock budget. The budget only grows
    // while D keeps winning against a waiting P, so P's worst-case wait is
    // bounded by MAX_LOCK+1 cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_D;
            lock_cnt   <= '0;
        end else begin
            if (p_take) begin
                last_owner <= OWN_P;
            end else if (d_take) begin
                last_owner <= OWN_D;
            end

            if (!(p_take || d_take) || p_take || !d_lock) begin
                lock_cnt <= '0;
            end else if (p_req && (lock_cnt != '1)) begin
                lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
            end
        end
    end

`ifdef ARB_STATS_EN
    // Saturating usage counters for grants and contested cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_p_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (p_take && (stat_p_grants != '1)) begin
                stat_p_grants <= stat_p_grants + STAT_W'(1);
            end
            if (d_take && (stat_d_grants != '1)) begin
                stat_d_grants <= stat_d_grants + STAT_W'(1);
            end
            if (p_req && d_req && (stat_conflicts != '1)) begin
                stat_conflicts <= stat_conflicts + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (the dmem instance, 16384 bytes, byte/half-word/sign-extend controls) between two requesters.
- Requester P is the processor's data port. Requester D is a DMA/loader engine that preloads and dumps memory regions, e.g. the sort array at byte 8192.
- Arbitrates per cycle: round-robin on ties, with an optional burst lock for D that is bounded by a starvation limit.
- Registers the read data back to the winner.

Parameters:
- ADDR_W, 32: address width; bit order [0:ADDR_W-1], MSB at index 0.
- DATA_W, 32: data width; bit order [0:DATA_W-1].
- MAX_LOCK, 16: maximum consecutive D grants under d_lock while p_req is pending; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- p_req  in  1  P access request
- p_addr  in  ADDR_W  P address
- p_wdata  in  DATA_W  P write data
- p_we  in  1  P write enable
- p_byte  in  1  P byte access
- p_half  in  1  P half-word access
- p_sext  in  1  P sign-extend on load
- p_gnt  out  1  P granted this cycle
- p_rdata  out  DATA_W  registered read data to P
- p_rvalid  out  1  p_rdata valid
- d_req, d_addr, d_wdata, d_we, d_byte, d_half, d_sext  in  same widths as the P inputs  D request and payload
- d_lock  in  1  D asks to keep ownership next cycle
- d_gnt, d_rdata, d_rvalid  out  same widths as the P outputs  D grant and read return
- addr_to_mem  out  ADDR_W  to dmem
- data_to_mem  out  DATA_W  to dmem
- write_enable_to_mem  out  1  to dmem
- byte_to_mem  out  1  to dmem
- half_word_to_mem  out  1  to dmem
- sign_extend_to_mem  out  1  to dmem
- data_from_mem  in  DATA_W  combinational read data from dmem

Behaviour:
- Reset values while reset=0: p_gnt=d_gnt=0, write_enable_to_mem=0, all other mem outputs 0, p_rvalid=d_rvalid=0, p_rdata=d_rdata=0, last_owner=D, lock_cnt=0.
- Arbitration runs each cycle in cycle N and is combinational from the requests and registered state:
  - Only one req high: that requester wins.
  - Both high and lock_hold true: D wins.
  - Otherwise the requester that was not last_owner wins.
- lock_hold = (last_owner==D) && d_lock && (lock_cnt < MAX_LOCK).
- Exactly one gnt is high if any req is high. gnt is never high without its req.
- The winner's payload drives the mem outputs. write_enable_to_mem = winner_we & gnt. With no req, the mem outputs hold 0.
- Writes commit at the rising edge ending cycle N.
- On a read, data_from_mem is sampled at that same edge into the winner's rdata. The winner's rvalid is high for exactly cycle N+1.
  - The other rdata holds its previous value.
  - Writes never raise rvalid.
  - Read latency = 1 cycle after gnt.
- Requester rule: hold req and payload stable until gnt is seen. A back-to-back request in cycle N+1 is legal.
- last_owner updates to the winner on every granted cycle and is unchanged on idle cycles.
- lock_cnt:
  - Increments (saturating at 255) on each D grant while p_req=1 and d_lock=1.
  - Clears on any P grant, on d_lock=0, and on idle cycles.
  - When lock_cnt reaches MAX_LOCK, P wins the next contested cycle. Worst-case P wait is MAX_LOCK+1 cycles.
- Simultaneous events:
  - Both requests in the first cycle after reset: P wins, because last_owner=D.
  - d_lock with d_req=0 has no effect.
  - p_req alone during a D lock: P is granted.
- Reset asserted mid-access: outputs drop asynchronously and any pending rvalid is lost. The write edge that coincides with reset assertion is not guaranteed.
- Address and size legality (alignment, range) is passed through unchanged. dmem owns it.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs stat_p_grants[0:15], stat_d_grants[0:15] and stat_conflicts[0:15]. The third counts cycles with p_req & d_req.
  - All three are saturating counters, reset to 0 on reset.
- Undefined: the ports and counters are absent and there is no other change.

Decomposition:
- Package dmem_arb_pkg holds:
  - the word and address width constants;
  - the owner_t enum {OWN_P, OWN_D};
  - the lock counter width constant (8).
- One natural sub-module, arb_pick: combinational winner selection from the reqs, last_owner, d_lock and lock_cnt. All flops stay in the top.

Test Plan:
- Single P read: p_req=1, p_addr=0x2000, dmem[0x2000..3]=0x0000002A -> p_gnt=1 in the same cycle; next cycle p_rvalid=1 and p_rdata=0x0000002A; d_rvalid=0.
- Contention tie after reset: p_req=d_req=1 for 4 cycles, d_lock=0 -> grant sequence P, D, P, D.
- D burst lock: MAX_LOCK=4, D holds its grant with d_lock=1, then p_req rises with d_req/d_lock still high -> D gets exactly 4 more grants, then P is granted; P waits ≤5 cycles.
- Write then read: D writes byte 0x7F to 0x2004 (d_byte=1), P reads 0x2004 with p_byte=1, p_sext=1 -> mem write_enable high only in the D cycle; p_rdata=0x0000007F.
- Reset mid-read: reset=0 in the cycle after a P read grant -> p_rvalid=0 immediately, all outputs at reset values; after release, a tie grants P first.
- ARB_STATS_EN: 3 P grants, 2 D grants, 2 conflict cycles -> stat_p_grants=3, stat_d_grants=2, stat_conflicts=2.
